// File: rtl/flag_alloc_ctrl.sv
// flag_alloc_ctrl: read-modify-write controller in front of the 3-read-port
// valid-flag memory of the hash table. Takes one insert/delete request at a
// time, reads the three candidate bucket masks, sets or clears one slot, writes
// the new mask back and strobes a one-cycle response.
// Optional feature: define FLAG_ALLOC_COUNT_EN to add the occupancy_o counter.
module flag_alloc_ctrl #(
    parameter int  SIZE        = 10,
    parameter int  BUCKET_SIZE = 4,
    localparam int SLOT_W      = (BUCKET_SIZE > 1) ? $clog2(BUCKET_SIZE) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_op_i,
    input  logic [SIZE-1:0]        req_adr_0_i,
    input  logic [SIZE-1:0]        req_adr_1_i,
    input  logic [SIZE-1:0]        req_adr_2_i,
    input  logic [1:0]             req_sel_i,
    input  logic [SLOT_W-1:0]      req_slot_i,
    output logic                   resp_valid_o,
    output logic                   resp_ok_o,
    output logic [1:0]             resp_sel_o,
    output logic [SLOT_W-1:0]      resp_slot_o,
    output logic                   flag_ready_o,
    output logic [SIZE-1:0]        flag_read_adr_0_o,
    output logic [SIZE-1:0]        flag_read_adr_1_o,
    output logic [SIZE-1:0]        flag_read_adr_2_o,
    output logic [SIZE-1:0]        flag_write_adr_o,
    output logic                   flag_write_en_o,
    output logic [BUCKET_SIZE-1:0] flag_write_is_valid_o,
    input  logic [BUCKET_SIZE-1:0] flag_in_0_i,
    input  logic [BUCKET_SIZE-1:0] flag_in_1_i,
    input  logic [BUCKET_SIZE-1:0] flag_in_2_i
`ifdef FLAG_ALLOC_COUNT_EN
    ,
    output logic [SIZE+$clog2(BUCKET_SIZE+1)-1:0] occupancy_o
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_EVAL, ST_RESP} state_t;

    state_t state, state_nxt, state_eff;

    // Request fields latched at accept, response fields latched at end of EVAL
    logic                   op_p0;
    logic [SIZE-1:0]        adr_p0 [3];
    logic [1:0]             sel_p0;
    logic [SLOT_W-1:0]      slot_p0;
    logic                   ok_p1;
    logic [1:0]             sel_p1;
    logic [SLOT_W-1:0]      slot_p1;

    logic [BUCKET_SIZE-1:0] cand_mask [3];
    logic [BUCKET_SIZE-1:0] hit_mask;
    logic [SIZE-1:0]        hit_adr;
    logic                   ev_ok;
    logic [1:0]             ev_sel;
    logic [SLOT_W-1:0]      ev_slot;
    logic [SIZE-1:0]        ev_adr;
    logic [BUCKET_SIZE-1:0] ev_mask;

    // Lowest-index clear bit of a mask (only meaningful when mask is not full)
    function automatic logic [SLOT_W-1:0] first_free_slot(input logic [BUCKET_SIZE-1:0] m);
        logic [SLOT_W-1:0] r;
        r = '0;
        for (int s = BUCKET_SIZE - 1; s >= 0; s--) begin
            if (!m[s]) r = SLOT_W'(s);
        end
        return r;
    endfunction

    // One-hot of a slot; an out-of-range slot shifts out to all zeros
    function automatic logic [BUCKET_SIZE-1:0] slot_onehot(input logic [SLOT_W-1:0] s);
        return BUCKET_SIZE'(1) << s;
    endfunction

    assign cand_mask[0] = flag_in_0_i;
    assign cand_mask[1] = flag_in_1_i;
    assign cand_mask[2] = flag_in_2_i;

    // Reset forces the decoded outputs to their idle values in the same cycle,
    // so a request caught mid-flight issues neither a write nor a response.
    assign state_eff = reset ? ST_IDLE : state;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic: only leaving IDLE depends on an input
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (req_valid_i) state_nxt = ST_READ;
            ST_READ: state_nxt = ST_EVAL;
            ST_EVAL: state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Stage p0: capture the request on accept
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && req_valid_i) begin
            op_p0     <= req_op_i;
            adr_p0[0] <= req_adr_0_i;
            adr_p0[1] <= req_adr_1_i;
            adr_p0[2] <= req_adr_2_i;
            sel_p0    <= req_sel_i;
            slot_p0   <= req_slot_i;
        end
    end

    // Decide which slot to set or clear from the masks returned by the memory
    always_comb begin
        ev_ok    = 1'b0;
        ev_sel   = '0;
        ev_slot  = '0;
        ev_adr   = '0;
        ev_mask  = '0;
        hit_mask = '0;
        hit_adr  = '0;
        if (!op_p0) begin
            // Walk from lowest priority upward so candidate 0 wins ties
            for (int k = 2; k >= 0; k--) begin
                if (!(&cand_mask[k])) begin
                    ev_ok   = 1'b1;
                    ev_sel  = 2'(k);
                    ev_slot = first_free_slot(cand_mask[k]);
                    ev_adr  = adr_p0[k];
                    ev_mask = cand_mask[k] | slot_onehot(first_free_slot(cand_mask[k]));
                end
            end
        end else begin
            case (sel_p0)
                2'd0: begin hit_mask = cand_mask[0]; hit_adr = adr_p0[0]; end
                2'd1: begin hit_mask = cand_mask[1]; hit_adr = adr_p0[1]; end
                2'd2: begin hit_mask = cand_mask[2]; hit_adr = adr_p0[2]; end
                default: begin hit_mask = '0; hit_adr = '0; end
            endcase
            if (|(hit_mask & slot_onehot(slot_p0))) begin
                ev_ok   = 1'b1;
                ev_sel  = sel_p0;
                ev_slot = slot_p0;
                ev_adr  = hit_adr;
                ev_mask = hit_mask & ~slot_onehot(slot_p0);
            end
        end
    end

    // Stage p1: hold the result for the RESP cycle
    always_ff @(posedge clk) begin
        if (state == ST_EVAL) begin
            ok_p1   <= ev_ok;
            sel_p1  <= ev_sel;
            slot_p1 <= ev_slot;
        end
    end

    // Output decode from the (reset-qualified) state
    always_comb begin
        req_ready_o           = 1'b0;
        resp_valid_o          = 1'b0;
        resp_ok_o             = 1'b0;
        resp_sel_o            = '0;
        resp_slot_o           = '0;
        flag_ready_o          = 1'b0;
        flag_read_adr_0_o     = '0;
        flag_read_adr_1_o     = '0;
        flag_read_adr_2_o     = '0;
        flag_write_en_o       = 1'b0;
        flag_write_adr_o      = '0;
        flag_write_is_valid_o = '0;
        case (state_eff)
            ST_IDLE: req_ready_o = 1'b1;
            ST_READ: begin
                flag_ready_o      = 1'b1;
                flag_read_adr_0_o = adr_p0[0];
                flag_read_adr_1_o = adr_p0[1];
                flag_read_adr_2_o = adr_p0[2];
            end
            ST_EVAL: begin
                flag_ready_o      = 1'b1;
                flag_read_adr_0_o = adr_p0[0];
                flag_read_adr_1_o = adr_p0[1];
                flag_read_adr_2_o = adr_p0[2];
                if (ev_ok) begin
                    flag_write_en_o       = 1'b1;
                    flag_write_adr_o      = ev_adr;
                    flag_write_is_valid_o = ev_mask;
                end
            end
            ST_RESP: begin
                resp_valid_o = 1'b1;
                resp_ok_o    = ok_p1;
                resp_sel_o   = sel_p1;
                resp_slot_o  = slot_p1;
            end
            default: req_ready_o = 1'b0;
        endcase
    end

`ifdef FLAG_ALLOC_COUNT_EN
    localparam int OCC_W = SIZE + $clog2(BUCKET_SIZE + 1);

    logic [OCC_W-1:0] occ_q;

    // Saturating up/down step of the occupancy count
    function automatic logic [OCC_W-1:0] occ_step(input logic [OCC_W-1:0] c,
                                                  input logic inc, input logic dec);
        if (inc && !(&c))       return c + OCC_W'(1);
        if (dec && (c != '0))   return c - OCC_W'(1);
        return c;
    endfunction

    // Occupancy counter, stepped at the end of EVAL on a successful operation
    always_ff @(posedge clk) begin
        if (reset)                  occ_q <= '0;
        else if (state == ST_EVAL)  occ_q <= occ_step(occ_q, ev_ok & ~op_p0, ev_ok & op_p0);
    end

    assign occupancy_o = occ_q;
`endif

endmodule

// File: tb/tb_flag_alloc_ctrl.sv
// Bench for flag_alloc_ctrl: models the flag memory, drives directed and
// random insert/delete requests and compares against a bucket-level model.
module tb_flag_alloc_ctrl;
    localparam int SIZE = 10;
    localparam int BKT  = 4;
    localparam logic [BKT-1:0] FULL = '1;

    logic            clk = 1'b0;
    logic            reset;
    logic            req_valid_i, req_ready_o, req_op_i;
    logic [SIZE-1:0] req_adr_0_i, req_adr_1_i, req_adr_2_i;
    logic [1:0]      req_sel_i, req_slot_i;
    logic            resp_valid_o, resp_ok_o;
    logic [1:0]      resp_sel_o, resp_slot_o;
    logic            flag_ready_o, flag_write_en_o;
    logic [SIZE-1:0] flag_read_adr_0_o, flag_read_adr_1_o, flag_read_adr_2_o, flag_write_adr_o;
    logic [BKT-1:0]  flag_write_is_valid_o, flag_in_0_i, flag_in_1_i, flag_in_2_i;
`ifdef FLAG_ALLOC_COUNT_EN
    logic [SIZE+2:0] occupancy_o;
`endif

    flag_alloc_ctrl #(.SIZE(SIZE), .BUCKET_SIZE(BKT)) dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_adr_0_i(req_adr_0_i), .req_adr_1_i(req_adr_1_i), .req_adr_2_i(req_adr_2_i),
        .req_sel_i(req_sel_i), .req_slot_i(req_slot_i),
        .resp_valid_o(resp_valid_o), .resp_ok_o(resp_ok_o),
        .resp_sel_o(resp_sel_o), .resp_slot_o(resp_slot_o),
        .flag_ready_o(flag_ready_o),
        .flag_read_adr_0_o(flag_read_adr_0_o), .flag_read_adr_1_o(flag_read_adr_1_o),
        .flag_read_adr_2_o(flag_read_adr_2_o),
        .flag_write_adr_o(flag_write_adr_o), .flag_write_en_o(flag_write_en_o),
        .flag_write_is_valid_o(flag_write_is_valid_o),
        .flag_in_0_i(flag_in_0_i), .flag_in_1_i(flag_in_1_i), .flag_in_2_i(flag_in_2_i)
`ifdef FLAG_ALLOC_COUNT_EN
        , .occupancy_o(occupancy_o)
`endif
    );

    always #5 clk = ~clk;

    // Flag memory: registered reads, write port gated by flag_ready_o
    logic [BKT-1:0]  mem [0:1023];
    logic            mem_clr, pre_we;
    logic [SIZE-1:0] pre_adr;
    logic [BKT-1:0]  pre_val;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
        end else if (pre_we) begin
            mem[pre_adr] <= pre_val;
        end else if (flag_ready_o && flag_write_en_o) begin
            mem[flag_write_adr_o] <= flag_write_is_valid_o;
        end
        if (flag_ready_o) begin
            flag_in_0_i <= mem[flag_read_adr_0_o];
            flag_in_1_i <= mem[flag_read_adr_1_o];
            flag_in_2_i <= mem[flag_read_adr_2_o];
        end
    end

    // Reference model state
    logic [BKT-1:0] ref_mem [0:1023];
    int             occ_m;

    int total = 0;
    int bad   = 0;

    logic            last_ok, last_w;
    logic [1:0]      last_sel, last_slot;
    logic [SIZE-1:0] last_wadr;
    logic [BKT-1:0]  last_wval;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected outcome of a request from the bucket contents of the model
    task automatic ref_eval(input logic op, input logic [SIZE-1:0] a0, a1, a2,
                            input logic [1:0] sel, input logic [1:0] slot,
                            output logic ok, output logic [1:0] esel, output logic [1:0] eslot,
                            output logic [SIZE-1:0] eadr, output logic [BKT-1:0] emask);
        logic [SIZE-1:0] a [3];
        logic [BKT-1:0]  m;
        int              fs;
        a[0] = a0; a[1] = a1; a[2] = a2;
        ok = 1'b0; esel = '0; eslot = '0; eadr = '0; emask = '0;
        if (op == 1'b0) begin
            for (int k = 0; k < 3; k++) begin
                if (!ok && ref_mem[a[k]] != FULL) begin
                    m  = ref_mem[a[k]];
                    fs = 0;
                    while (((m >> fs) & 4'd1) != 4'd0) fs++;
                    ok    = 1'b1;
                    esel  = 2'(k);
                    eslot = 2'(fs);
                    eadr  = a[k];
                    emask = m | (4'd1 << fs);
                end
            end
        end else if (sel != 2'd3) begin
            m = ref_mem[a[sel]];
            if (m[slot]) begin
                ok    = 1'b1;
                esel  = sel;
                eslot = slot;
                eadr  = a[sel];
                emask = m & ~(4'd1 << slot);
            end
        end
    endtask

    task automatic preload(input logic [SIZE-1:0] a, input logic [BKT-1:0] v);
        @(negedge clk);
        pre_we = 1'b1; pre_adr = a; pre_val = v;
        @(posedge clk);
        #1 pre_we = 1'b0;
        ref_mem[a] = v;
    endtask

    // One full request: accept, observe four cycles, compare with the model
    task automatic do_req(input logic op, input logic [SIZE-1:0] a0, a1, a2,
                          input logic [1:0] sel, input logic [1:0] slot);
        logic            e_ok, r_ok, w_seen;
        logic [1:0]      e_sel, e_slot, r_sel, r_slot;
        logic [SIZE-1:0] e_adr, w_adr;
        logic [BKT-1:0]  e_mask, w_val;
        int              n, resp_cnt, r_idx, w_idx;
        ref_eval(op, a0, a1, a2, sel, slot, e_ok, e_sel, e_slot, e_adr, e_mask);
        n = 0;
        while (req_ready_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (req_ready_o !== 1'b1) begin
            chk("ready_wait", 32'(req_ready_o), 32'(1));
            return;
        end
        req_op_i = op; req_adr_0_i = a0; req_adr_1_i = a1; req_adr_2_i = a2;
        req_sel_i = sel; req_slot_i = slot; req_valid_i = 1'b1;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        req_op_i    = 1'($urandom);
        req_adr_0_i = 10'($urandom); req_adr_1_i = 10'($urandom); req_adr_2_i = 10'($urandom);
        req_sel_i   = 2'($urandom);  req_slot_i  = 2'($urandom);
        resp_cnt = 0; r_idx = 0; w_idx = 0; w_seen = 1'b0;
        r_ok = 1'b0; r_sel = '0; r_slot = '0; w_adr = '0; w_val = '0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (flag_write_en_o === 1'b1) begin
                w_seen = 1'b1; w_idx = i; w_adr = flag_write_adr_o; w_val = flag_write_is_valid_o;
            end
            if (resp_valid_o === 1'b1) begin
                resp_cnt++; r_idx = i; r_ok = resp_ok_o; r_sel = resp_sel_o; r_slot = resp_slot_o;
            end
            chk("ready_busy", 32'(req_ready_o), 32'(i == 4));
            chk("flag_ready", 32'(flag_ready_o), 32'(i <= 2));
        end
        chk("resp_count", 32'(resp_cnt), 32'(1));
        chk("resp_latency", 32'(r_idx), 32'(3));
        chk("resp_ok", 32'(r_ok), 32'(e_ok));
        chk("resp_sel", 32'(r_sel), 32'(e_sel));
        chk("resp_slot", 32'(r_slot), 32'(e_slot));
        chk("write_seen", 32'(w_seen), 32'(e_ok));
        if (e_ok) begin
            chk("write_cycle", 32'(w_idx), 32'(2));
            chk("write_adr", 32'(w_adr), 32'(e_adr));
            chk("write_mask", 32'(w_val), 32'(e_mask));
            ref_mem[e_adr] = e_mask;
            if (!op) occ_m = occ_m + 1;
            else     occ_m = (occ_m > 0) ? occ_m - 1 : 0;
        end
        chk("mem_adr0", 32'(mem[a0]), 32'(ref_mem[a0]));
        chk("mem_adr1", 32'(mem[a1]), 32'(ref_mem[a1]));
        chk("mem_adr2", 32'(mem[a2]), 32'(ref_mem[a2]));
`ifdef FLAG_ALLOC_COUNT_EN
        chk("occupancy", 32'(occupancy_o), 32'(occ_m));
`endif
        last_ok = r_ok; last_sel = r_sel; last_slot = r_slot;
        last_w = w_seen; last_wadr = w_adr; last_wval = w_val;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req_valid_i = 1'b0; req_op_i = 1'b0;
        req_adr_0_i = '0; req_adr_1_i = '0; req_adr_2_i = '0;
        req_sel_i = '0; req_slot_i = '0;
        mem_clr = 1'b1; pre_we = 1'b0; pre_adr = '0; pre_val = '0;
        occ_m = 0;
        last_ok = 1'b0; last_w = 1'b0; last_sel = '0; last_slot = '0; last_wadr = '0; last_wval = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
        repeat (2) @(posedge clk);
        #1 mem_clr = 1'b0;

        // Outputs while reset is held
        @(negedge clk);
        chk("rst_ready", 32'(req_ready_o), 32'(1));
        chk("rst_resp_valid", 32'(resp_valid_o), 32'(0));
        chk("rst_resp_ok", 32'(resp_ok_o), 32'(0));
        chk("rst_flag_ready", 32'(flag_ready_o), 32'(0));
        chk("rst_write_en", 32'(flag_write_en_o), 32'(0));
        chk("rst_write_adr", 32'(flag_write_adr_o), 32'(0));
        chk("rst_read_adr0", 32'(flag_read_adr_0_o), 32'(0));
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready_o), 32'(1));
`ifdef FLAG_ALLOC_COUNT_EN
        chk("rst_occupancy", 32'(occupancy_o), 32'(0));
`endif

        // Insert into empty buckets
        do_req(1'b0, 10'd5, 10'd9, 10'd12, 2'd0, 2'd0);
        chk("t1_ok", 32'(last_ok), 32'(1));
        chk("t1_sel", 32'(last_sel), 32'(0));
        chk("t1_slot", 32'(last_slot), 32'(0));
        chk("t1_wadr", 32'(last_wadr), 32'(5));
        chk("t1_wval", 32'(last_wval), 32'(4'b0001));

        // First candidate full, second has slot 2 free
        preload(10'd30, 4'b1111);
        preload(10'd31, 4'b1011);
        do_req(1'b0, 10'd30, 10'd31, 10'd32, 2'd0, 2'd0);
        chk("t2_ok", 32'(last_ok), 32'(1));
        chk("t2_sel", 32'(last_sel), 32'(1));
        chk("t2_slot", 32'(last_slot), 32'(2));
        chk("t2_wadr", 32'(last_wadr), 32'(31));
        chk("t2_wval", 32'(last_wval), 32'(4'b1111));

        // All candidates full
        preload(10'd40, 4'b1111);
        preload(10'd41, 4'b1111);
        preload(10'd42, 4'b1111);
        do_req(1'b0, 10'd40, 10'd41, 10'd42, 2'd0, 2'd0);
        chk("t3_ok", 32'(last_ok), 32'(0));
        chk("t3_write", 32'(last_w), 32'(0));
        chk("t3_sel", 32'(last_sel), 32'(0));
        chk("t3_slot", 32'(last_slot), 32'(0));

        // Delete sel=2 slot=1, then the same delete again
        preload(10'd52, 4'b0110);
        do_req(1'b1, 10'd50, 10'd51, 10'd52, 2'd2, 2'd1);
        chk("t4_ok", 32'(last_ok), 32'(1));
        chk("t4_wadr", 32'(last_wadr), 32'(52));
        chk("t4_wval", 32'(last_wval), 32'(4'b0100));
        do_req(1'b1, 10'd50, 10'd51, 10'd52, 2'd2, 2'd1);
        chk("t4b_ok", 32'(last_ok), 32'(0));
        chk("t4b_write", 32'(last_w), 32'(0));
        // Delete with sel=3
        do_req(1'b1, 10'd50, 10'd51, 10'd52, 2'd3, 2'd2);
        chk("t4c_ok", 32'(last_ok), 32'(0));

        // Reset while the request is in EVAL
        @(negedge clk);
        req_op_i = 1'b0; req_adr_0_i = 10'd200; req_adr_1_i = 10'd201; req_adr_2_i = 10'd202;
        req_sel_i = '0; req_slot_i = '0; req_valid_i = 1'b1;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_write_en", 32'(flag_write_en_o), 32'(0));
        chk("mid_rst_resp", 32'(resp_valid_o), 32'(0));
        @(posedge clk);
        #1 reset = 1'b0;
        occ_m = 0;
        @(negedge clk);
        chk("mid_rst_ready", 32'(req_ready_o), 32'(1));
        chk("mid_rst_resp2", 32'(resp_valid_o), 32'(0));
        @(negedge clk);
        chk("mid_rst_resp3", 32'(resp_valid_o), 32'(0));
        chk("mid_rst_mem", 32'(mem[200]), 32'(ref_mem[200]));
`ifdef FLAG_ALLOC_COUNT_EN
        chk("mid_rst_occ", 32'(occupancy_o), 32'(0));
`endif

        // Back-to-back inserts into one address triple
        for (int j = 0; j < 5; j++) begin
            do_req(1'b0, 10'd100, 10'd101, 10'd102, 2'd0, 2'd0);
            chk("b2b_ok", 32'(last_ok), 32'(1));
            chk("b2b_sel", 32'(last_sel), 32'((j < 4) ? 1'b0 : 1'b1));
            chk("b2b_slot", 32'(last_slot), 32'((j < 4) ? j : 0));
        end
`ifdef FLAG_ALLOC_COUNT_EN
        chk("b2b_occ", 32'(occupancy_o), 32'(5));
`endif

        // Random traffic over a small address range to force collisions
        repeat (80) begin
            do_req(($urandom_range(0, 9) < 6) ? 1'b0 : 1'b1,
                   10'($urandom_range(0, 7)), 10'($urandom_range(0, 7)), 10'($urandom_range(0, 7)),
                   2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/flag_alloc_ctrl.md
Name: flag_alloc_ctrl

Overview:
Read-modify-write controller sitting directly in front of the 3-read-port valid-flag memory of the hash table. It accepts one insert or delete request at a time, each carrying three candidate bucket addresses from the hash stage. It reads the bucket occupancy masks, picks or clears one slot, writes the updated mask back, and reports the result.
One request is in flight at a time, so there are no read-after-write hazards on the flag memory.

Parameters:
SIZE, 10, bucket address width; the flag memory has 2**SIZE buckets.
BUCKET_SIZE, 4, slots per bucket; width of one occupancy mask.
SLOT_W, derived localparam (not overridable), $clog2(BUCKET_SIZE) if BUCKET_SIZE>1, else 1.

Ports:
clk  in  1  single clock
reset  in  1  synchronous, active-high
req_valid_i  in  1  request valid
req_ready_o  out  1  controller can accept a request
req_op_i  in  1  0 = insert, 1 = delete
req_adr_0_i / req_adr_1_i / req_adr_2_i  in  SIZE each  candidate bucket addresses, priority 0 > 1 > 2
req_sel_i  in  2  delete only: candidate index 0..2 holding the entry
req_slot_i  in  SLOT_W  delete only: slot to clear
resp_valid_o  out  1  one-cycle result strobe
resp_ok_o  out  1  operation succeeded
resp_sel_o  out  2  candidate index used
resp_slot_o  out  SLOT_W  slot set or cleared
flag_ready_o  out  1  enable for the flag memory's read and write ports
flag_read_adr_0_o / _1_o / _2_o  out  SIZE each  flag memory read addresses
flag_write_adr_o  out  SIZE  flag memory write address
flag_write_en_o  out  1  flag memory write enable
flag_write_is_valid_o  out  BUCKET_SIZE  new occupancy mask
flag_in_0_i / flag_in_1_i / flag_in_2_i  in  BUCKET_SIZE each  registered flag memory read data; 1-cycle read latency

Behaviour:
- FSM states: IDLE -> READ -> EVAL -> RESP -> IDLE. Every transition is unconditional except leaving IDLE.
- IDLE
  - req_ready_o=1.
  - On req_valid_i && req_ready_o: latch op, the three addresses, sel and slot; go to READ.
- READ
  - flag_ready_o=1; flag_read_adr_k_o = latched addresses.
  - The flag memory samples the addresses at the end of this cycle.
- EVAL
  - flag_ready_o=1; flag_in_k_i are valid in this cycle.
- EVAL, insert:
  - Choose the lowest k in 0,1,2 whose mask is not all-ones.
  - Within that mask choose the lowest-index 0 bit s.
  - Drive flag_write_en_o=1, flag_write_adr_o=adr_k, flag_write_is_valid_o=mask_k | (1<<s).
  - If all three masks are all-ones: no write, ok=0.
- EVAL, delete:
  - k=req_sel; check bit s=req_slot of mask_k.
  - Bit set: write mask_k & ~(1<<s) to adr_k, ok=1.
  - Bit clear: no write, ok=0.
  - req_sel=3 or req_slot>=BUCKET_SIZE: no write, ok=0.
- Duplicate candidate addresses are legal. Priority resolves them; only one write is issued per request.
- RESP
  - resp_valid_o=1 for exactly one cycle, with resp_ok_o/resp_sel_o/resp_slot_o registered at the end of EVAL.
  - There is no response backpressure.
  - When ok=0: resp_sel_o and resp_slot_o are 0.
- Latency and throughput:
  - Accept edge E0; write commits at E2; resp_valid_o is high in the cycle after E2.
  - Next accept is no earlier than the edge after RESP, giving a 4-cycle throughput.
  - A write commits at least 2 edges before the next read samples, so the next request always sees the updated mask.
- flag_write_en_o is high only in EVAL. flag_ready_o is high only in READ and EVAL.
- Reset
  - Outputs: state=IDLE; req_ready_o=1; all resp_* and flag_* outputs 0.
  - Reset mid-operation: the request is dropped, with no write and no response.
  - The flag memory contents are not cleared by this block.

Optional Feature:
FLAG_ALLOC_COUNT_EN
- Defined:
  - Adds output occupancy_o [SIZE+$clog2(BUCKET_SIZE+1)-1:0], reset to 0.
  - +1 on each successful insert and -1 on each successful delete, updated at the EVAL edge.
  - Saturates at 0 and at its maximum.
- Undefined: the port and counter are absent.

Test Plan:
- Insert, adr 5/9/12, all masks 0000 -> write adr 5 mask 0001; resp ok=1 sel=0 slot=0; resp 3 cycles after accept.
- Insert, adr0 mask 1111, adr1 mask 1011 -> write adr1 mask 1111; resp ok=1 sel=1 slot=2.
- Insert, all three masks 1111 -> flag_write_en_o stays 0 throughout; resp ok=0 sel=0 slot=0.
- Delete sel=2 slot=1, mask 0110 -> write mask 0100, ok=1. Repeat the same delete -> ok=0, no write.
- Back-to-back inserts, same adr triple starting from empty -> slots 0,1,2,3 in order, then a 5th goes to sel=1; req_ready_o low from the accept edge until RESP ends.
- reset asserted in EVAL -> no flag_write_en_o, no resp_valid_o; req_ready_o=1 the next cycle. With FLAG_ALLOC_COUNT_EN, occupancy_o=0 after reset and 5 after the 5 inserts.
